// File: rtl/iq_pkg.sv
// Shared types and constants for the compacting issue queue.
// Entry layout, issue window width and counter sizing.
package iq_pkg;

  localparam int ISSUE_W   = 3;
  localparam int IQ_DATA_W = 32;
  localparam int IQ_TAG_W  = 6;

  typedef struct packed {
    logic                 valid;
    logic                 ready;
    logic [IQ_TAG_W-1:0]  tag;
    logic [IQ_DATA_W-1:0] data;
  } iq_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/iq_shift_calc.sv
// Per-entry collapse distance: number of issued slots below each entry.
// Pure combinational table driven by the 3-bit issue vector.
module iq_shift_calc
  import iq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [ISSUE_W-1:0]    ins,
  output logic [DEPTH-1:0][1:0] shift
);

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      shift[j] = 2'd0;
      for (int k = 0; k < ISSUE_W; k++) begin
        if (k < j) shift[j] = shift[j] + {1'b0, ins[k]};
      end
    end
  end

endmodule

// File: rtl/iq_compact_issue.sv
// Collapsing issue queue: issues up to 3 ready ops from entries 0..2,
// compacts survivors toward entry 0, and appends one dispatch at the tail.
module iq_compact_issue
  import iq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = IQ_DATA_W,
  parameter int TAG_W  = IQ_TAG_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_valid,
  input  logic [DATA_W-1:0]         disp_data,
  input  logic [TAG_W-1:0]          disp_tag,
  input  logic                      disp_rdy_now,
  output logic                      disp_ready,
  input  logic                      wake_valid,
  input  logic [TAG_W-1:0]          wake_tag,
  input  logic                      issue_en,
  output logic [ISSUE_W-1:0]        issue_valid,
  output logic [ISSUE_W*DATA_W-1:0] issue_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  iq_entry_t q  [DEPTH];
  iq_entry_t nq [DEPTH];

  logic [ISSUE_W-1:0]    ins;
  logic [DEPTH-1:0]      gone;
  logic [DEPTH-1:0][1:0] shift;
  logic [1:0]            n_iss;
  logic                  disp_ok;
  logic [CW-1:0]         count_n;
  int                    tail;

  assign disp_ready = (count != CW'(DEPTH));
  assign disp_ok    = disp_valid & disp_ready;

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      ins[k] = issue_en & q[k].valid & q[k].ready;
    end
    n_iss = {1'b0, ins[0]} + {1'b0, ins[1]} + {1'b0, ins[2]};
    gone  = DEPTH'(ins);
  end

  iq_shift_calc #(
    .DEPTH (DEPTH)
  ) u_shift (
    .ins   (ins),
    .shift (shift)
  );

  // Scatter survivors downward; wakeup rides along with the move.
  always_comb begin
    for (int d = 0; d < DEPTH; d++) nq[d] = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (q[j].valid && !gone[j]) begin
        nq[j - int'(shift[j])] = q[j];
        if (wake_valid && q[j].tag == wake_tag) begin
          nq[j - int'(shift[j])].ready = 1'b1;
        end
      end
    end
    tail = int'(count) - int'(n_iss);
    if (disp_ok) begin
      nq[tail].valid = 1'b1;
      nq[tail].ready = disp_rdy_now
                     | (wake_valid && disp_tag == wake_tag);
      nq[tail].tag   = disp_tag;
      nq[tail].data  = disp_data;
    end
    count_n = count - CW'(n_iss) + CW'(disp_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count       <= '0;
      issue_valid <= '0;
      issue_data  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
      count       <= count_n;
      issue_valid <= ins;
      for (int k = 0; k < ISSUE_W; k++) begin
        issue_data[k*DATA_W +: DATA_W] <= ins[k] ? q[k].data : '0;
      end
    end
  end

endmodule

// File: tb/tb_iq_compact_issue.sv
// Directed bench for the compacting issue queue.
// Observes issue slots, count and disp_ready after each rising edge.
module tb_iq_compact_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid;
  logic [31:0] disp_data;
  logic [5:0]  disp_tag;
  logic        disp_rdy_now;
  logic        disp_ready;
  logic        wake_valid;
  logic [5:0]  wake_tag;
  logic        issue_en;
  logic [2:0]  issue_valid;
  logic [95:0] issue_data;
  logic [3:0]  count;

  int n_vec = 0;
  int n_err = 0;

  iq_compact_issue #(
    .DEPTH  (8),
    .DATA_W (32),
    .TAG_W  (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .disp_valid   (disp_valid),
    .disp_data    (disp_data),
    .disp_tag     (disp_tag),
    .disp_rdy_now (disp_rdy_now),
    .disp_ready   (disp_ready),
    .wake_valid   (wake_valid),
    .wake_tag     (wake_tag),
    .issue_en     (issue_en),
    .issue_valid  (issue_valid),
    .issue_data   (issue_data),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [31:0] d,
                      input logic [5:0]  t,
                      input logic        r);
    disp_valid   = 1'b1;
    disp_data    = d;
    disp_tag     = t;
    disp_rdy_now = r;
    step();
    disp_valid   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    disp_valid = 0; disp_data = '0; disp_tag = '0; disp_rdy_now = 0;
    wake_valid = 0; wake_tag = '0; issue_en = 0;
    #1;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_ivalid", 128'(issue_valid), 128'd0);
    chk("rst_idata", 128'(issue_data), 128'd0);
    chk("rst_dready", 128'(disp_ready), 128'd1);
    step();
    rst = 1'b0;
    step();

    // three ready ops, issue disabled
    disp(32'hA0, 6'd1, 1'b1);
    disp(32'hA1, 6'd1, 1'b1);
    disp(32'hA2, 6'd1, 1'b1);
    chk("fill3_count", 128'(count), 128'd3);
    chk("fill3_ivalid", 128'(issue_valid), 128'd0);

    issue_en = 1'b1;
    step();
    issue_en = 1'b0;
    chk("iss3_ivalid", 128'(issue_valid), 128'b111);
    chk("iss3_idata", 128'(issue_data), {32'h0, 32'hA2, 32'hA1, 32'hA0});
    chk("iss3_count", 128'(count), 128'd0);
    step();
    chk("idle_ivalid", 128'(issue_valid), 128'd0);

    // eight entries, entry1 waits on tag 5
    disp(32'h10, 6'd1, 1'b1);
    disp(32'h11, 6'd5, 1'b0);
    for (int i = 2; i < 8; i++) disp(32'h10 + 32'(i), 6'd1, 1'b1);
    chk("full_count", 128'(count), 128'd8);
    chk("full_dready", 128'(disp_ready), 128'd0);

    issue_en = 1'b1;
    step();
    issue_en = 1'b0;
    chk("hole_ivalid", 128'(issue_valid), 128'b101);
    chk("hole_idata", 128'(issue_data), {32'h0, 32'h12, 32'h0, 32'h10});
    chk("hole_count", 128'(count), 128'd6);

    wake_valid = 1'b1; wake_tag = 6'd5;
    step();
    wake_valid = 1'b0;
    chk("wake_ivalid", 128'(issue_valid), 128'd0);
    chk("wake_count", 128'(count), 128'd6);

    issue_en = 1'b1;
    step();
    chk("woke_ivalid", 128'(issue_valid), 128'b111);
    chk("woke_idata", 128'(issue_data), {32'h0, 32'h14, 32'h13, 32'h11});
    chk("woke_count", 128'(count), 128'd3);
    step();
    issue_en = 1'b0;
    chk("drain_idata", 128'(issue_data), {32'h0, 32'h17, 32'h16, 32'h15});
    chk("drain_count", 128'(count), 128'd0);

    // refill to full with a hole at entry1 (tag 9)
    disp(32'h30, 6'd1, 1'b1);
    disp(32'h31, 6'd9, 1'b0);
    for (int i = 2; i < 8; i++) disp(32'h30 + 32'(i), 6'd1, 1'b1);
    chk("full2_count", 128'(count), 128'd8);

    disp_valid = 1'b1; disp_data = 32'h99; disp_tag = 6'd1;
    disp_rdy_now = 1'b1; issue_en = 1'b1;
    step();
    disp_valid = 1'b0; issue_en = 1'b0;
    chk("refuse_ivalid", 128'(issue_valid), 128'b101);
    chk("refuse_idata", 128'(issue_data), {32'h0, 32'h32, 32'h0, 32'h30});
    chk("refuse_count", 128'(count), 128'd6);
    chk("refuse_dready", 128'(disp_ready), 128'd1);

    // wake tag 9 while issuing; woken entry stays at entry 0
    wake_valid = 1'b1; wake_tag = 6'd9; issue_en = 1'b1;
    step();
    wake_valid = 1'b0; issue_en = 1'b0;
    chk("part_ivalid", 128'(issue_valid), 128'b110);
    chk("part_idata", 128'(issue_data), {32'h34, 32'h33, 32'h0});
    chk("part_count", 128'(count), 128'd4);
    disp(32'h3F, 6'd1, 1'b1);
    chk("pre_rst_count", 128'(count), 128'd5);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 128'(count), 128'd0);
    chk("arst_ivalid", 128'(issue_valid), 128'd0);
    chk("arst_dready", 128'(disp_ready), 128'd1);
    #1;
    rst = 1'b0;
    step();

    // dispatch woken in arrival cycle; empty queue issues nothing
    disp_valid = 1'b1; disp_data = 32'h77; disp_tag = 6'd7;
    disp_rdy_now = 1'b0; wake_valid = 1'b1; wake_tag = 6'd7;
    issue_en = 1'b1;
    step();
    disp_valid = 1'b0; wake_valid = 1'b0;
    chk("arr_ivalid", 128'(issue_valid), 128'd0);
    chk("arr_count", 128'(count), 128'd1);
    step();
    issue_en = 1'b0;
    chk("arr2_ivalid", 128'(issue_valid), 128'b001);
    chk("arr2_idata", 128'(issue_data), {32'h0, 32'h0, 32'h77});
    chk("arr2_count", 128'(count), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
